// File: rtl/ram_bus_master_if.sv
// ram_bus_master_if
//   Client-side handshake bundle for ram_bus_master.
//   master modport : the bus initiator (ram_bus_master) side
//   slave  modport : the on-chip client (DMA / loader / video fetch) side
// Signals
//   REQ, WE, ADDR, LEN   burst request, direction, start address, words-1
//   BUSY, DONE           burst in progress / one-cycle end-of-burst pulse
//   WDATA, WVALID, WREADY write word handshake
//   RDATA, RVALID        read word, valid for one cycle, no backpressure
interface ram_bus_master_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                  REQ;
    logic                  WE;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [LEN_WIDTH-1:0]  LEN;
    logic                  BUSY;
    logic                  DONE;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RVALID;

    modport master (
        input  REQ, WE, ADDR, LEN, WDATA, WVALID,
        output BUSY, DONE, WREADY, RDATA, RVALID
    );

    modport slave (
        output REQ, WE, ADDR, LEN, WDATA, WVALID,
        input  BUSY, DONE, WREADY, RDATA, RVALID
    );
endinterface

// File: rtl/ram_bus_master.sv
// ram_bus_master
//   Burst initiator for a single-port synchronous RAM with a one-cycle
//   registered read. Runs LEN+1 sequential reads or writes from ADDR,
//   hiding read latency and DIO turnaround from the client.
// Ports
//   CLK, RST       clock, synchronous active-high reset
//   bus            client handshake (ram_bus_master_if.master)
//   RAM_A          registered RAM address
//   RAM_DIO        bidirectional RAM data, driven only during write cycles
//   RAM_CS_N, RAM_OE_N, RAM_WR_N  registered active-low RAM strobes
module ram_bus_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    ram_bus_master_if.master      bus,
    output logic [ADDR_WIDTH-1:0] RAM_A,
    inout  logic [DATA_WIDTH-1:0] RAM_DIO,
    output logic                  RAM_CS_N,
    output logic                  RAM_OE_N,
    output logic                  RAM_WR_N
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DRAIN,
        RD_LAST,
        WR_DATA,
        WR_END
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  CNT_ONE  = LEN_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic                  cs_n_q, cs_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  wr_n_q, wr_n_d;
    logic                  drive_q, drive_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  done_q, done_d;
    // Read valid pipeline: p0 = address presented, p1 = RAM has registered
    // the word; the l* bits flag the final word of the burst.
    logic                  p0_q, p0_d, l0_q, l0_d;
    logic                  p1_q, p1_d, l1_q, l1_d;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.REQ) begin
                    if (bus.WE) begin
                        state_d = WR_DATA;
                    end else if (bus.LEN == '0) begin
                        // single word: the only address is already issued
                        state_d = RD_DRAIN;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: state_d = RD_LAST;
            RD_LAST:  state_d = IDLE;
            WR_DATA: begin
                if (bus.WVALID && (cnt_q == '0)) begin
                    state_d = WR_END;
                end
            end
            WR_END:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ram_a_d = ram_a_q;
        cs_n_d  = cs_n_q;
        oe_n_d  = oe_n_q;
        wr_n_d  = 1'b1;
        drive_d = 1'b0;
        dout_d  = dout_q;
        p0_d    = 1'b0;
        l0_d    = 1'b0;
        p1_d    = p0_q;
        l1_d    = l0_q;
        // DIO is sampled two edges after its address was presented.
        rvalid_d = p1_q;
        rdata_d  = p1_q ? RAM_DIO : rdata_q;
        done_d   = (p1_q && l1_q) || (state_q == WR_END);

        case (state_q)
            IDLE: begin
                if (bus.REQ) begin
                    cnt_d  = bus.LEN;
                    addr_d = bus.ADDR;
                    if (!bus.WE) begin
                        ram_a_d = bus.ADDR;
                        addr_d  = bus.ADDR + ADDR_ONE;
                        cs_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                        p0_d    = 1'b1;
                        l0_d    = (bus.LEN == '0);
                    end
                end
            end
            RD_ISSUE: begin
                ram_a_d = addr_q;
                addr_d  = addr_q + ADDR_ONE;
                cnt_d   = cnt_q - CNT_ONE;
                p0_d    = 1'b1;
                l0_d    = (cnt_q == CNT_ONE);
            end
            RD_DRAIN: begin
                // hold strobes and address so the RAM registers the last word
            end
            RD_LAST: begin
                cs_n_d = 1'b1;
                oe_n_d = 1'b1;
            end
            WR_DATA: begin
                if (bus.WVALID) begin
                    ram_a_d = addr_q;
                    dout_d  = bus.WDATA;
                    drive_d = 1'b1;
                    cs_n_d  = 1'b0;
                    wr_n_d  = 1'b0;
                    oe_n_d  = 1'b1;
                    addr_d  = addr_q + ADDR_ONE;
                    cnt_d   = cnt_q - CNT_ONE;
                end else begin
                    cs_n_d = 1'b1;
                end
            end
            WR_END: begin
                cs_n_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Registered outputs and counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            ram_a_q  <= '0;
            cs_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            drive_q  <= 1'b0;
            dout_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            p0_q     <= 1'b0;
            l0_q     <= 1'b0;
            p1_q     <= 1'b0;
            l1_q     <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            ram_a_q  <= ram_a_d;
            cs_n_q   <= cs_n_d;
            oe_n_q   <= oe_n_d;
            wr_n_q   <= wr_n_d;
            drive_q  <= drive_d;
            dout_q   <= dout_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            p0_q     <= p0_d;
            l0_q     <= l0_d;
            p1_q     <= p1_d;
            l1_q     <= l1_d;
        end
    end

    // drive_q is only ever set alongside WR_N=0 / OE_N=1
    assign RAM_DIO  = drive_q ? dout_q : 'z;
    assign RAM_A    = ram_a_q;
    assign RAM_CS_N = cs_n_q;
    assign RAM_OE_N = oe_n_q;
    assign RAM_WR_N = wr_n_q;

    assign bus.BUSY   = (state_q != IDLE);
    assign bus.WREADY = (state_q == WR_DATA);
    assign bus.RDATA  = rdata_q;
    assign bus.RVALID = rvalid_q;
    assign bus.DONE   = done_q;

endmodule
